// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex glyph table and the pin polarity helper.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs indexed by nibble; bit SEG_A is bit 0, SEG_G is bit 6.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic pin_level(input logic lit, input logic active_low);
        return lit ^ active_low;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-high a..g segment decode.
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] row;

    always_comb begin
        row        = SEG_LUT[nibble];
        seg        = '0;
        seg[SEG_A] = row[SEG_A];
        seg[SEG_B] = row[SEG_B];
        seg[SEG_C] = row[SEG_C];
        seg[SEG_D] = row[SEG_D];
        seg[SEG_E] = row[SEG_E];
        seg[SEG_F] = row[SEG_F];
        seg[SEG_G] = row[SEG_G];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-synchronous double buffering,
// blanking, decimal points and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic SEG_AL = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_AL = (DIG_ACTIVE_LOW != 0);

    logic [PRE_W-1:0]        pre_reg, pre_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] act_value_reg, pend_value_reg, view_value;
    logic [NUM_DIGITS-1:0]   act_dp_reg, pend_dp_reg, view_dp;
    logic [NUM_DIGITS-1:0]   act_blank_reg, pend_blank_reg, view_blank;
    logic                    pend_valid_reg;
    logic                    tc, wrap, slot_gap;

    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   dig_en_reg, dig_en_next;
    logic                    frame_done_reg;

    always_comb begin
        tc       = (pre_reg == PRE_LAST);
        wrap     = tc && (idx_reg == IDX_LAST);
        pre_next = tc ? '0 : pre_reg + PRE_W'(1);
        if (!tc) begin
            idx_next = idx_reg;
        end else if (wrap) begin
            idx_next = '0;
        end else begin
            idx_next = idx_reg + IDX_W'(1);
        end
        // The output register looks one cycle ahead, so the TC cycle goes dark.
        slot_gap = (pre_next == PRE_LAST);
    end

    // Contents of the active buffer as they will be after this edge; lets a
    // load or pending swap at the frame boundary show on digit 0 immediately.
    always_comb begin
        view_value = act_value_reg;
        view_dp    = act_dp_reg;
        view_blank = act_blank_reg;
        if (wrap && load) begin
            view_value = value;
            view_dp    = dp_in;
            view_blank = blank_in;
        end else if (wrap && pend_valid_reg) begin
            view_value = pend_value_reg;
            view_dp    = pend_dp_reg;
            view_blank = pend_blank_reg;
        end
    end

    logic [NUM_DIGITS-1:0] zero_or_blank, dark;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic nib_zero, upper_clear;
            assign nib_zero          = (view_value[4*gi +: 4] == 4'h0);
            assign zero_or_blank[gi] = nib_zero || view_blank[gi];
            // Zero here and nothing visible above means this is a leading zero.
            always_comb begin
                upper_clear = 1'b1;
                for (int j = gi; j < NUM_DIGITS; j++) begin
                    upper_clear = upper_clear & zero_or_blank[j];
                end
            end
            assign dark[gi] = view_blank[gi] || (lz_en && (gi != 0) && nib_zero && upper_clear);
        end
    endgenerate

    logic [3:0] sel_nib;
    logic [6:0] sel_seg;
    logic       sel_dark, sel_dp;

    assign sel_nib  = view_value[4*idx_next +: 4];
    assign sel_dark = dark[idx_next];
    assign sel_dp   = view_dp[idx_next] && !view_blank[idx_next];

    hex7seg_decode u_decode (
        .nibble (sel_nib),
        .seg    (sel_seg)
    );

    generate
        for (gi = 0; gi < 7; gi++) begin : g_seg_pin
            assign seg_next[gi] = pin_level(!slot_gap && !sel_dark && sel_seg[gi], SEG_AL);
        end
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig_pin
            assign dig_en_next[gi] = pin_level(!slot_gap && (idx_next == IDX_W'(gi)), DIG_AL);
        end
    endgenerate

    assign dp_next = pin_level(!slot_gap && sel_dp, SEG_AL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg        <= '0;
            idx_reg        <= '0;
            act_value_reg  <= '0;
            act_dp_reg     <= '0;
            act_blank_reg  <= '0;
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            pend_blank_reg <= '0;
            pend_valid_reg <= 1'b0;
            seg_reg        <= {7{pin_level(1'b0, SEG_AL)}};
            dp_reg         <= pin_level(1'b0, SEG_AL);
            dig_en_reg     <= {NUM_DIGITS{pin_level(1'b0, DIG_AL)}};
            frame_done_reg <= 1'b0;
        end else begin
            pre_reg <= pre_next;
            idx_reg <= idx_next;
            if (wrap) begin
                act_value_reg  <= view_value;
                act_dp_reg     <= view_dp;
                act_blank_reg  <= view_blank;
                pend_valid_reg <= 1'b0;
            end else if (load) begin
                pend_value_reg <= value;
                pend_dp_reg    <= dp_in;
                pend_blank_reg <= blank_in;
                pend_valid_reg <= 1'b1;
            end
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            dig_en_reg     <= dig_en_next;
            frame_done_reg <= wrap;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign dig_en     = dig_en_reg;
    assign frame_done = frame_done_reg;

endmodule
